// File: rtl/vanilla_sb_clear_arb_pkg.sv
// Shared types for the scoreboard-clear arbiter: one clear request = {is_float, register id}.
package vanilla_sb_clear_arb_pkg;

    localparam int unsigned reg_addr_width_gp = 5;

    typedef struct packed {
        logic                         is_float;
        logic [reg_addr_width_gp-1:0] id;
    } sb_clear_req_s;

    localparam int unsigned sb_clear_req_width_gp = $bits(sb_clear_req_s);

endpackage

// File: rtl/vanilla_sb_rr_picker.sv
// N-way round-robin picker: grants the first valid index at or after the pointer, then
// moves the pointer just past the grantee; pointer holds when nothing is requesting.
module vanilla_sb_rr_picker #(
    parameter  int unsigned num_req_p    = 4,
    localparam int unsigned ptr_width_lp = $clog2(num_req_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [num_req_p-1:0]    v_i,
    output logic [num_req_p-1:0]    grant_o,
    output logic [ptr_width_lp-1:0] ptr_o
);

    logic [ptr_width_lp-1:0] ptr_r;
    logic [ptr_width_lp-1:0] ptr_n;
    logic                    found;
    logic [ptr_width_lp-1:0] idx;

    always_comb begin
        grant_o = '0;
        ptr_n   = ptr_r;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned off = 0; off < num_req_p; off++) begin
            idx = ptr_width_lp'((32'(ptr_r) + off) % num_req_p);
            if (!found && v_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                ptr_n        = ptr_width_lp'((32'(idx) + 32'd1) % num_req_p);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_r <= '0;
        end else if (found) begin
            ptr_r <= ptr_n;
        end
    end

    assign ptr_o = ptr_r;

endmodule

// File: rtl/vanilla_sb_clear_arbiter.sv
// Shares the int and float scoreboard-clear ports among num_req_p sources with per-file RR.
// Optional VANILLA_SB_CLEAR_ARB_STATS_EN adds saturating conflict / x0-drop counters.
module vanilla_sb_clear_arbiter
    import vanilla_sb_clear_arb_pkg::*;
#(
    parameter  int unsigned num_req_p         = 4,
    parameter  int unsigned max_wait_p        = 64,
    localparam int unsigned reg_addr_width_lp = reg_addr_width_gp,
    localparam int unsigned idx_width_lp      = $clog2(num_req_p),
    localparam int unsigned cnt_width_lp      = $clog2(max_wait_p + 1)
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic          [num_req_p-1:0]   v_i,
    input  sb_clear_req_s [num_req_p-1:0]   req_i,
    output logic          [num_req_p-1:0]   yumi_o,
    output logic                            int_sb_clear_o,
    output logic [reg_addr_width_lp-1:0]    int_sb_clear_id_o,
    output logic                            float_sb_clear_o,
    output logic [reg_addr_width_lp-1:0]    float_sb_clear_id_o,
`ifdef VANILLA_SB_CLEAR_ARB_STATS_EN
    output logic [31:0]                     int_conflict_cnt_o,
    output logic [31:0]                     float_conflict_cnt_o,
    output logic [31:0]                     x0_drop_cnt_o,
`endif
    output logic                            starve_o,
    output logic [idx_width_lp-1:0]         starve_idx_o
);

    logic [num_req_p-1:0]         v_int;
    logic [num_req_p-1:0]         v_flt;
    logic [num_req_p-1:0]         int_grant;
    logic [num_req_p-1:0]         flt_grant;
    logic [idx_width_lp-1:0]      int_ptr;
    logic [idx_width_lp-1:0]      flt_ptr;
    logic [reg_addr_width_lp-1:0] int_id_c;
    logic [reg_addr_width_lp-1:0] flt_id_c;
    logic                         int_fire_c;
    logic                         flt_fire_c;

    // Nothing is granted while in reset, so pending requests restart from pointer 0.
    always_comb begin
        v_int    = '0;
        v_flt    = '0;
        int_id_c = '0;
        flt_id_c = '0;
        for (int i = 0; i < num_req_p; i++) begin
            v_int[i] = v_i[i] & ~reset_i & ~req_i[i].is_float;
            v_flt[i] = v_i[i] & ~reset_i &  req_i[i].is_float;
            if (int_grant[i]) int_id_c = int_id_c | req_i[i].id;
            if (flt_grant[i]) flt_id_c = flt_id_c | req_i[i].id;
        end
    end

    vanilla_sb_rr_picker #(.num_req_p(num_req_p)) int_pick (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (v_int),
        .grant_o (int_grant),
        .ptr_o   (int_ptr)
    );

    vanilla_sb_rr_picker #(.num_req_p(num_req_p)) flt_pick (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (v_flt),
        .grant_o (flt_grant),
        .ptr_o   (flt_ptr)
    );

    assign yumi_o     = int_grant | flt_grant;
    // x0 is hardwired zero: accept the request but never clear it.
    assign int_fire_c = (|int_grant) && (int_id_c != '0);
    assign flt_fire_c = |flt_grant;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            int_sb_clear_o      <= 1'b0;
            int_sb_clear_id_o   <= '0;
            float_sb_clear_o    <= 1'b0;
            float_sb_clear_id_o <= '0;
        end else begin
            int_sb_clear_o      <= int_fire_c;
            int_sb_clear_id_o   <= int_fire_c ? int_id_c : '0;
            float_sb_clear_o    <= flt_fire_c;
            float_sb_clear_id_o <= flt_fire_c ? flt_id_c : '0;
        end
    end

    logic [num_req_p-1:0][cnt_width_lp-1:0] wait_r;
    logic [num_req_p-1:0][cnt_width_lp-1:0] wait_n;
    logic                                   hit_c;
    logic [idx_width_lp-1:0]                hit_idx_c;

    // Starvation watchdog: saturating wait count per requester, lowest hitting index wins.
    always_comb begin
        wait_n    = wait_r;
        hit_c     = 1'b0;
        hit_idx_c = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (!v_i[i] || yumi_o[i]) begin
                wait_n[i] = '0;
            end else if (wait_r[i] < cnt_width_lp'(max_wait_p)) begin
                wait_n[i] = wait_r[i] + cnt_width_lp'(1);
            end
            if (!hit_c && (wait_n[i] == cnt_width_lp'(max_wait_p))) begin
                hit_c     = 1'b1;
                hit_idx_c = idx_width_lp'(i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wait_r       <= '0;
            starve_o     <= 1'b0;
            starve_idx_o <= '0;
        end else begin
            wait_r <= wait_n;
            if (!starve_o && hit_c) begin
                starve_o     <= 1'b1;
                starve_idx_o <= hit_idx_c;
            end
        end
    end

`ifdef VANILLA_SB_CLEAR_ARB_STATS_EN
    logic int_conflict_c;
    logic flt_conflict_c;
    logic x0_drop_c;

    assign int_conflict_c = (v_int & (v_int - num_req_p'(1))) != '0;
    assign flt_conflict_c = (v_flt & (v_flt - num_req_p'(1))) != '0;
    assign x0_drop_c      = (|int_grant) && (int_id_c == '0);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            int_conflict_cnt_o   <= '0;
            float_conflict_cnt_o <= '0;
            x0_drop_cnt_o        <= '0;
        end else begin
            if (int_conflict_c && int_conflict_cnt_o != '1)   int_conflict_cnt_o   <= int_conflict_cnt_o + 32'd1;
            if (flt_conflict_c && float_conflict_cnt_o != '1) float_conflict_cnt_o <= float_conflict_cnt_o + 32'd1;
            if (x0_drop_c && x0_drop_cnt_o != '1)             x0_drop_cnt_o        <= x0_drop_cnt_o + 32'd1;
        end
    end
`endif

    // A waiting requester must keep v_i and req_i stable until accepted.
    for (genvar g = 0; g < num_req_p; g++) begin : g_hold_chk
        a_hold : assert property (@(posedge clk_i) disable iff (reset_i)
            (v_i[g] && !yumi_o[g]) |=> (v_i[g] && (req_i[g] == $past(req_i[g]))));
    end

endmodule

// File: tb/tb_vanilla_sb_clear_arbiter.sv
// Randomized bench for vanilla_sb_clear_arbiter against a request-list reference model.
// Define VANILLA_SB_CLEAR_ARB_STATS_EN to also check the statistics counters.
module tb_vanilla_sb_clear_arbiter;
    import vanilla_sb_clear_arb_pkg::*;

    localparam int N    = 4;
    localparam int MAXW = 3;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [N-1:0]          v;
    sb_clear_req_s [N-1:0] req;
    logic [N-1:0]          yumi;
    logic                  int_clr, flt_clr;
    logic [4:0]            int_id, flt_id;
    logic                  starve;
    logic [1:0]            starve_idx;
`ifdef VANILLA_SB_CLEAR_ARB_STATS_EN
    logic [31:0]           int_conf, flt_conf, x0_drop;
`endif

    always #5 clk = ~clk;

    vanilla_sb_clear_arbiter #(.num_req_p(N), .max_wait_p(MAXW)) dut (
        .clk_i               (clk),
        .reset_i             (reset),
        .v_i                 (v),
        .req_i               (req),
        .yumi_o              (yumi),
        .int_sb_clear_o      (int_clr),
        .int_sb_clear_id_o   (int_id),
        .float_sb_clear_o    (flt_clr),
        .float_sb_clear_id_o (flt_id),
`ifdef VANILLA_SB_CLEAR_ARB_STATS_EN
        .int_conflict_cnt_o  (int_conf),
        .float_conflict_cnt_o(flt_conf),
        .x0_drop_cnt_o       (x0_drop),
`endif
        .starve_o            (starve),
        .starve_idx_o        (starve_idx)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Outstanding requests per requester (what the bench is presenting).
    bit pend[N];
    bit pf[N];
    int pid[N];
    bit rand_mode = 1'b0;

    // Reference model state.
    int m_ptr_i, m_ptr_f;
    int m_wait[N];
    bit m_starve;
    int m_starve_idx;
    bit m_iclr, m_fclr;
    int m_iid, m_fid;
    int m_iconf, m_fconf, m_x0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    // First pending request of the wanted kind at or after ptr, wrapping; -1 when none.
    function automatic int pick(input int ptr, input bit want_float);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (pend[i] && pf[i] == want_float) return i;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input bit is_f, input int id);
        pend[i] = 1'b1;
        pf[i]   = is_f;
        pid[i]  = id;
    endtask

    task automatic cycle(input bit rst);
        int gi, gf, ci, cf;
        bit [N-1:0] g;
        bit hit;
        int hidx;
        reset = rst;
        for (int i = 0; i < N; i++) begin
            v[i]          = pend[i];
            req[i].is_float = pf[i];
            req[i].id     = 5'(pid[i]);
        end
        #1;
        g  = '0;
        gi = -1;
        gf = -1;
        if (!rst) begin
            gi = pick(m_ptr_i, 1'b0);
            gf = pick(m_ptr_f, 1'b1);
            if (gi >= 0) g[gi] = 1'b1;
            if (gf >= 0) g[gf] = 1'b1;
        end
        check("yumi", 32'(yumi), 32'(g));
        @(posedge clk);
        #1;
        if (rst) begin
            m_ptr_i = 0; m_ptr_f = 0;
            for (int i = 0; i < N; i++) m_wait[i] = 0;
            m_starve = 1'b0; m_starve_idx = 0;
            m_iclr = 1'b0; m_fclr = 1'b0; m_iid = 0; m_fid = 0;
            m_iconf = 0; m_fconf = 0; m_x0 = 0;
        end else begin
            m_iclr = 1'b0; m_iid = 0; m_fclr = 1'b0; m_fid = 0;
            if (gi >= 0) begin
                m_ptr_i = (gi + 1) % N;
                if (pid[gi] != 0) begin m_iclr = 1'b1; m_iid = pid[gi]; end
                else m_x0++;
            end
            if (gf >= 0) begin
                m_ptr_f = (gf + 1) % N;
                m_fclr  = 1'b1;
                m_fid   = pid[gf];
            end
            ci = 0; cf = 0;
            for (int i = 0; i < N; i++) begin
                if (pend[i] && !pf[i]) ci++;
                if (pend[i] &&  pf[i]) cf++;
            end
            if (ci >= 2) m_iconf++;
            if (cf >= 2) m_fconf++;
            hit = 1'b0; hidx = 0;
            for (int i = 0; i < N; i++) begin
                if (pend[i] && !g[i]) begin
                    if (m_wait[i] < MAXW) m_wait[i]++;
                end else m_wait[i] = 0;
                if (!hit && m_wait[i] == MAXW) begin hit = 1'b1; hidx = i; end
            end
            if (!m_starve && hit) begin m_starve = 1'b1; m_starve_idx = hidx; end
            for (int i = 0; i < N; i++) if (g[i]) pend[i] = 1'b0;
        end
        check("int_clr",    32'(int_clr),    32'(m_iclr));
        check("int_id",     32'(int_id),     32'(m_iid));
        check("flt_clr",    32'(flt_clr),    32'(m_fclr));
        check("flt_id",     32'(flt_id),     32'(m_fid));
        check("starve",     32'(starve),     32'(m_starve));
        check("starve_idx", 32'(starve_idx), 32'(m_starve_idx));
`ifdef VANILLA_SB_CLEAR_ARB_STATS_EN
        check("int_conf", int_conf, 32'(m_iconf));
        check("flt_conf", flt_conf, 32'(m_fconf));
        check("x0_drop",  x0_drop,  32'(m_x0));
`endif
        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    set_req(i, $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin pend[i] = 1'b0; pf[i] = 1'b0; pid[i] = 0; end
        cycle(1'b1);
        cycle(1'b1);
        // Single int request: yumi now, clear of id 5 next cycle, quiet after.
        set_req(0, 1'b0, 5);
        repeat (3) cycle(1'b0);
        // Four int requests held from reset: served 0,1,2,3; the last one starves (max wait 3).
        cycle(1'b1);
        for (int i = 0; i < N; i++) set_req(i, 1'b0, i + 1);
        cycle(1'b1);
        repeat (6) cycle(1'b0);
        cycle(1'b1);
        // Same id on both files in one cycle.
        set_req(1, 1'b1, 7);
        set_req(2, 1'b0, 7);
        repeat (2) cycle(1'b0);
        // x0 request accepted without a clear.
        set_req(3, 1'b0, 0);
        repeat (2) cycle(1'b0);
        // Reset right after a grant of id 9; leftovers restart from pointer 0.
        set_req(0, 1'b0, 9);
        set_req(2, 1'b0, 4);
        set_req(3, 1'b0, 3);
        set_req(1, 1'b1, 6);
        set_req(3, 1'b0, 3);
        cycle(1'b0);
        cycle(1'b1);
        repeat (4) cycle(1'b0);
        // Random traffic with occasional resets.
        rand_mode = 1'b1;
        for (int c = 0; c < 600; c++) cycle($urandom_range(0, 49) == 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
